pipelined_control_unit: RTL and testbench

Control unit for the five-stage RV32I pipeline. It decodes the full RV32I base opcode set in Decode (D) and carries the resulting control word through the ID/EX, EX/MEM and MEM/WB registers. It resolves branches and jumps in Execute (E) and honours stall and flush requests from the hazard unit. It replaces the single-cycle control path: wider control fields, registered per-stage outputs, and a full set of branch conditions.

---
 rtl/control_pkg.sv | 108 ++++++++++
 rtl/rv32i_decoder.sv | 105 ++++++++++
 rtl/pipelined_control_unit.sv | 138 +++++++++++++
 tb/tb_pipelined_control_unit.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/control_pkg.sv
// Shared definitions for the RV32I pipelined control path.
// Contents:
//   - base opcode and branch funct3 constants
//   - ALU, immediate-format, result-source and PC-source encodings
//   - the control word carried through the pipeline
//   - the bubble constant
//   - aluFromFunct3, the ALU-op helper shared by R-type and I-type ALU decode
package control_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD    = 4'b0000,
        ALU_SUB    = 4'b0001,
        ALU_AND    = 4'b0010,
        ALU_OR     = 4'b0011,
        ALU_XOR    = 4'b0100,
        ALU_SLT    = 4'b0101,
        ALU_SLTU   = 4'b0110,
        ALU_SLL    = 4'b0111,
        ALU_SRL    = 4'b1000,
        ALU_SRA    = 4'b1001,
        ALU_PASS_B = 4'b1010
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I = 3'b000,
        IMM_S = 3'b001,
        IMM_B = 3'b010,
        IMM_U = 3'b011,
        IMM_J = 3'b100
    } imm_src_t;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_t;

    typedef enum logic [1:0] {
        PC_PLUS4  = 2'b00,
        PC_TARGET = 2'b01,
        PC_ALU    = 2'b10
    } pc_src_t;

    typedef struct packed {
        logic        reg_write;
        result_src_t result_src;
        logic        mem_write;
        logic [2:0]  funct3;
        alu_op_t     alu_control;
        logic        alu_src_a;
        logic        alu_src_b;
        logic        branch;
        logic        jump;
        logic        jalr;
    } ctrl_word_t;

    // A bubble writes nothing and never redirects the PC.
    localparam ctrl_word_t CTRL_BUBBLE = '{
        reg_write:   1'b0,
        result_src:  RES_ALU,
        mem_write:   1'b0,
        funct3:      3'b000,
        alu_control: ALU_ADD,
        alu_src_a:   1'b0,
        alu_src_b:   1'b0,
        branch:      1'b0,
        jump:        1'b0,
        jalr:        1'b0
    };

    // The alt bit selects SUB for funct3 000 and SRA for funct3 101;
    // callers decide when the alt bit is meaningful.
    function automatic alu_op_t aluFromFunct3(input logic [2:0] f3, input logic alt);
        alu_op_t op;
        op = ALU_ADD;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I decoder for the Decode stage.
// Ports:
//   i_opcode    instruction[6:0]
//   i_funct3    instruction[14:12]
//   i_funct7_5  instruction[30]
//   o_ctrl      control word; a bubble when the instruction is illegal
//   o_imm_src   immediate format
//   o_illegal   opcode/funct combination is not in the RV32I base set
module rv32i_decoder
    import control_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output ctrl_word_t o_ctrl,
    output imm_src_t   o_imm_src,
    output logic       o_illegal
);

    ctrl_word_t w_ctrl;
    logic       w_illegal;

    // Build the control word field by field from a bubble, then replace it
    // with a bubble again if any legality check failed, so an illegal
    // instruction never leaks write or redirect enables into the pipeline.
    always_comb begin
        w_ctrl        = CTRL_BUBBLE;
        w_ctrl.funct3 = i_funct3;
        o_imm_src     = IMM_I;
        w_illegal     = 1'b0;
        case (i_opcode)
            OP_LUI: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_control = ALU_PASS_B;
                w_ctrl.alu_src_b   = 1'b1;
                o_imm_src          = IMM_U;
            end
            OP_AUIPC: begin
                w_ctrl.reg_write = 1'b1;
                w_ctrl.alu_src_a = 1'b1;
                w_ctrl.alu_src_b = 1'b1;
                o_imm_src        = IMM_U;
            end
            OP_JAL: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.result_src = RES_PC4;
                w_ctrl.alu_src_a  = 1'b1;
                w_ctrl.alu_src_b  = 1'b1;
                w_ctrl.jump       = 1'b1;
                o_imm_src         = IMM_J;
            end
            OP_JALR: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.result_src = RES_PC4;
                w_ctrl.alu_src_b  = 1'b1;
                w_ctrl.jalr       = 1'b1;
                w_illegal         = (i_funct3 != 3'b000);
            end
            OP_BRANCH: begin
                w_ctrl.branch      = 1'b1;
                w_ctrl.alu_control = ALU_SUB;
                o_imm_src          = IMM_B;
                w_illegal          = (i_funct3 == 3'b010) || (i_funct3 == 3'b011);
            end
            OP_LOAD: begin
                w_ctrl.reg_write  = 1'b1;
                w_ctrl.result_src = RES_MEM;
                w_ctrl.alu_src_b  = 1'b1;
                w_illegal         = (i_funct3 == 3'b011) || (i_funct3 == 3'b110) ||
                                    (i_funct3 == 3'b111);
            end
            OP_STORE: begin
                w_ctrl.mem_write = 1'b1;
                w_ctrl.alu_src_b = 1'b1;
                o_imm_src        = IMM_S;
                w_illegal        = (i_funct3[2] == 1'b1) || (i_funct3 == 3'b011);
            end
            OP_IMM: begin
                // Only the right shift uses bit 30; SLLI with it set is not RV32I.
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_src_b   = 1'b1;
                w_ctrl.alu_control = aluFromFunct3(i_funct3,
                                                   (i_funct3 == 3'b101) && i_funct7_5);
                w_illegal          = (i_funct3 == 3'b001) && i_funct7_5;
            end
            OP_REG: begin
                w_ctrl.reg_write   = 1'b1;
                w_ctrl.alu_control = aluFromFunct3(i_funct3, i_funct7_5);
                w_illegal          = i_funct7_5 && (i_funct3 != 3'b000) &&
                                     (i_funct3 != 3'b101);
            end
            // FENCE and ECALL/EBREAK retire as bubbles; FENCE.I and CSR
            // accesses belong to extensions and are rejected.
            OP_FENCE, OP_SYSTEM: begin
                w_illegal = (i_funct3 != 3'b000);
            end
            default: begin
                w_illegal = 1'b1;
            end
        endcase
        o_illegal = w_illegal;
        o_ctrl    = w_illegal ? CTRL_BUBBLE : w_ctrl;
    end

endmodule

// File: rtl/pipelined_control_unit.sv
// Control unit for the five-stage RV32I pipeline: decodes in D, carries the
// control word through ID/EX, EX/MEM and MEM/WB, and resolves branches/jumps in E.
// Ports:
//   clk, rst                      clock and async active-high reset
//   opcode_d, funct3_d, funct7_5_d instruction fields in D
//   stall_e, flush_e              hazard-unit hold / bubble requests for ID/EX
//   zero_e, lt_e, ltu_e           ALU compare flags in E
//   imm_src_d, illegal_d          combinational D outputs
//   alu_control_e, alu_src_a_e, alu_src_b_e, pc_src_e, reg_write_e, result_src_e
//   reg_write_m, result_src_m, mem_write_m, mem_funct3_m
//   reg_write_w, result_src_w
module pipelined_control_unit
    import control_pkg::*;
#(
    parameter int ALU_CTRL_W = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            opcode_d,
    input  logic [2:0]            funct3_d,
    input  logic                  funct7_5_d,
    input  logic                  stall_e,
    input  logic                  flush_e,
    input  logic                  zero_e,
    input  logic                  lt_e,
    input  logic                  ltu_e,
    output logic [2:0]            imm_src_d,
    output logic                  illegal_d,
    output logic [ALU_CTRL_W-1:0] alu_control_e,
    output logic                  alu_src_a_e,
    output logic                  alu_src_b_e,
    output logic [1:0]            pc_src_e,
    output logic                  reg_write_e,
    output logic [1:0]            result_src_e,
    output logic                  reg_write_m,
    output logic [1:0]            result_src_m,
    output logic                  mem_write_m,
    output logic [2:0]            mem_funct3_m,
    output logic                  reg_write_w,
    output logic [1:0]            result_src_w
);

    ctrl_word_t  w_ctrlD;
    imm_src_t    w_immSrc;
    logic        w_branchTaken;

    ctrl_word_t  r_idEx;
    logic        r_exMemRegWrite;
    result_src_t r_exMemResultSrc;
    logic        r_exMemMemWrite;
    logic [2:0]  r_exMemFunct3;
    logic        r_memWbRegWrite;
    result_src_t r_memWbResultSrc;

    rv32i_decoder u_decoder (
        .i_opcode   (opcode_d),
        .i_funct3   (funct3_d),
        .i_funct7_5 (funct7_5_d),
        .o_ctrl     (w_ctrlD),
        .o_imm_src  (w_immSrc),
        .o_illegal  (illegal_d)
    );

    assign imm_src_d = w_immSrc;

    // Flush is checked before stall so a simultaneous request yields a bubble.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idEx <= CTRL_BUBBLE;
        end else if (flush_e) begin
            r_idEx <= CTRL_BUBBLE;
        end else if (!stall_e) begin
            r_idEx <= w_ctrlD;
        end
    end

    // Downstream of E nothing stalls; only the fields later stages use are kept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_exMemRegWrite  <= 1'b0;
            r_exMemResultSrc <= RES_ALU;
            r_exMemMemWrite  <= 1'b0;
            r_exMemFunct3    <= 3'b000;
            r_memWbRegWrite  <= 1'b0;
            r_memWbResultSrc <= RES_ALU;
        end else begin
            r_exMemRegWrite  <= r_idEx.reg_write;
            r_exMemResultSrc <= r_idEx.result_src;
            r_exMemMemWrite  <= r_idEx.mem_write;
            r_exMemFunct3    <= r_idEx.funct3;
            r_memWbRegWrite  <= r_exMemRegWrite;
            r_memWbResultSrc <= r_exMemResultSrc;
        end
    end

    // Branch condition from the funct3 held in ID/EX; 010/011 never reach
    // here as branches because D turns them into bubbles.
    always_comb begin
        w_branchTaken = 1'b0;
        case (r_idEx.funct3)
            F3_BEQ:  w_branchTaken = zero_e;
            F3_BNE:  w_branchTaken = !zero_e;
            F3_BLT:  w_branchTaken = lt_e;
            F3_BGE:  w_branchTaken = !lt_e;
            F3_BLTU: w_branchTaken = ltu_e;
            F3_BGEU: w_branchTaken = !ltu_e;
            default: w_branchTaken = 1'b0;
        endcase
    end

    always_comb begin
        if (r_idEx.jalr) begin
            pc_src_e = PC_ALU;
        end else if (r_idEx.jump || (r_idEx.branch && w_branchTaken)) begin
            pc_src_e = PC_TARGET;
        end else begin
            pc_src_e = PC_PLUS4;
        end
    end

    // Wider ALU control buses carry the 4-bit op zero-extended.
    always_comb begin
        alu_control_e      = '0;
        alu_control_e[3:0] = r_idEx.alu_control;
    end

    assign alu_src_a_e  = r_idEx.alu_src_a;
    assign alu_src_b_e  = r_idEx.alu_src_b;
    assign reg_write_e  = r_idEx.reg_write;
    assign result_src_e = r_idEx.result_src;
    assign reg_write_m  = r_exMemRegWrite;
    assign result_src_m = r_exMemResultSrc;
    assign mem_write_m  = r_exMemMemWrite;
    assign mem_funct3_m = r_exMemFunct3;
    assign reg_write_w  = r_memWbRegWrite;
    assign result_src_w = r_memWbResultSrc;

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Scoreboard bench for pipelined_control_unit: stimulus pushes expected
// (cycle, signal, value) entries; the monitor compares on the falling edge
// of the cycle each entry names.
module tb_pipelined_control_unit;
    import control_pkg::*;

    typedef enum int {
        S_ALU_E, S_SRCA_E, S_SRCB_E, S_PCSRC_E, S_RW_E, S_RS_E,
        S_RW_M, S_RS_M, S_MW_M, S_F3_M, S_RW_W, S_RS_W, S_IMM_D, S_ILL_D
    } sig_t;

    typedef struct {
        int         cyc;
        sig_t       sig;
        logic [3:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode_d;
    logic [2:0] funct3_d;
    logic       funct7_5_d;
    logic       stall_e, flush_e;
    logic       zero_e, lt_e, ltu_e;
    logic [2:0] imm_src_d;
    logic       illegal_d;
    logic [3:0] alu_control_e;
    logic       alu_src_a_e, alu_src_b_e;
    logic [1:0] pc_src_e;
    logic       reg_write_e, reg_write_m, reg_write_w;
    logic [1:0] result_src_e, result_src_m, result_src_w;
    logic       mem_write_m;
    logic [2:0] mem_funct3_m;

    exp_t sb[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   c;

    pipelined_control_unit #(.ALU_CTRL_W(4)) dut (
        .clk(clk), .rst(rst),
        .opcode_d(opcode_d), .funct3_d(funct3_d), .funct7_5_d(funct7_5_d),
        .stall_e(stall_e), .flush_e(flush_e),
        .zero_e(zero_e), .lt_e(lt_e), .ltu_e(ltu_e),
        .imm_src_d(imm_src_d), .illegal_d(illegal_d),
        .alu_control_e(alu_control_e), .alu_src_a_e(alu_src_a_e),
        .alu_src_b_e(alu_src_b_e), .pc_src_e(pc_src_e),
        .reg_write_e(reg_write_e), .result_src_e(result_src_e),
        .reg_write_m(reg_write_m), .result_src_m(result_src_m),
        .mem_write_m(mem_write_m), .mem_funct3_m(mem_funct3_m),
        .reg_write_w(reg_write_w), .result_src_w(result_src_w)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [3:0] getSig(input sig_t s);
        case (s)
            S_ALU_E:   return alu_control_e;
            S_SRCA_E:  return {3'b000, alu_src_a_e};
            S_SRCB_E:  return {3'b000, alu_src_b_e};
            S_PCSRC_E: return {2'b00, pc_src_e};
            S_RW_E:    return {3'b000, reg_write_e};
            S_RS_E:    return {2'b00, result_src_e};
            S_RW_M:    return {3'b000, reg_write_m};
            S_RS_M:    return {2'b00, result_src_m};
            S_MW_M:    return {3'b000, mem_write_m};
            S_F3_M:    return {1'b0, mem_funct3_m};
            S_RW_W:    return {3'b000, reg_write_w};
            S_RS_W:    return {2'b00, result_src_w};
            S_IMM_D:   return {1'b0, imm_src_d};
            default:   return {3'b000, illegal_d};
        endcase
    endfunction

    function automatic string sigName(input sig_t s);
        case (s)
            S_ALU_E:   return "alu_control_e";
            S_SRCA_E:  return "alu_src_a_e";
            S_SRCB_E:  return "alu_src_b_e";
            S_PCSRC_E: return "pc_src_e";
            S_RW_E:    return "reg_write_e";
            S_RS_E:    return "result_src_e";
            S_RW_M:    return "reg_write_m";
            S_RS_M:    return "result_src_m";
            S_MW_M:    return "mem_write_m";
            S_F3_M:    return "mem_funct3_m";
            S_RW_W:    return "reg_write_w";
            S_RS_W:    return "result_src_w";
            S_IMM_D:   return "imm_src_d";
            default:   return "illegal_d";
        endcase
    endfunction

    task automatic pushExp(input int cy, input sig_t s, input logic [3:0] v);
        exp_t e;
        e.cyc = cy;
        e.sig = s;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic checkOutput(input exp_t e);
        logic [3:0] act;
        act = getSig(e.sig);
        checks++;
        if (act !== e.val) begin
            $display("[TB] FAIL %s cycle %0d: got %0d, expected %0d",
                     sigName(e.sig), cyc, act, e.val);
        end else begin
            passes++;
        end
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic [2:0] f3, input logic f7);
        opcode_d   = op;
        funct3_d   = f3;
        funct7_5_d = f7;
    endtask

    task automatic idle();
        applyStimulus(7'b0000000, 3'b000, 1'b0);
    endtask

    task automatic setFlags(input logic z, input logic l, input logic lu);
        zero_e = z;
        lt_e   = l;
        ltu_e  = lu;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every entry due in the current cycle on the falling edge.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                checkOutput(sb[i]);
                sb.delete(i);
            end
        end
    end

    initial begin
        rst = 1'b1;
        stall_e = 1'b0;
        flush_e = 1'b0;
        idle();
        setFlags(1'b0, 1'b0, 1'b0);

        // Reset state
        step(); step();
        pushExp(cyc, S_RW_E, 4'd0);
        pushExp(cyc, S_RW_M, 4'd0);
        pushExp(cyc, S_RW_W, 4'd0);
        pushExp(cyc, S_PCSRC_E, 4'd0);
        pushExp(cyc, S_MW_M, 4'd0);
        rst = 1'b0;

        // SUB flow through E, M, W
        step(); c = cyc;
        applyStimulus(OP_REG, 3'b000, 1'b1);
        pushExp(c, S_ILL_D, 4'd0);
        pushExp(c + 1, S_ALU_E, 4'd1);
        pushExp(c + 1, S_RW_E, 4'd1);
        pushExp(c + 2, S_RW_M, 4'd1);
        pushExp(c + 3, S_RW_W, 4'd1);
        pushExp(c + 3, S_RS_W, 4'd0);

        // BLTU taken (zero set too), BLTU not taken, BGE taken, BNE not taken
        step(); c = cyc;
        applyStimulus(OP_BRANCH, 3'b110, 1'b0);
        pushExp(c, S_IMM_D, 4'd2);
        step();
        setFlags(1'b1, 1'b0, 1'b1);
        applyStimulus(OP_BRANCH, 3'b110, 1'b0);
        pushExp(c + 1, S_PCSRC_E, 4'd1);
        pushExp(c + 1, S_ALU_E, 4'd1);
        pushExp(c + 1, S_RW_E, 4'd0);
        step();
        setFlags(1'b1, 1'b1, 1'b0);
        applyStimulus(OP_BRANCH, 3'b101, 1'b0);
        pushExp(c + 2, S_PCSRC_E, 4'd0);
        step();
        setFlags(1'b0, 1'b0, 1'b1);
        applyStimulus(OP_BRANCH, 3'b001, 1'b0);
        pushExp(c + 3, S_PCSRC_E, 4'd1);
        step();
        setFlags(1'b1, 1'b0, 1'b0);
        idle();
        pushExp(c + 4, S_PCSRC_E, 4'd0);
        step();
        setFlags(1'b0, 1'b0, 1'b0);

        // JALR
        step(); c = cyc;
        applyStimulus(OP_JALR, 3'b000, 1'b0);
        pushExp(c, S_IMM_D, 4'd0);
        pushExp(c + 1, S_PCSRC_E, 4'd2);
        pushExp(c + 1, S_SRCB_E, 4'd1);
        pushExp(c + 3, S_RW_W, 4'd1);
        pushExp(c + 3, S_RS_W, 4'd2);

        // JAL
        step(); c = cyc;
        applyStimulus(OP_JAL, 3'b000, 1'b0);
        pushExp(c, S_IMM_D, 4'd4);
        pushExp(c + 1, S_PCSRC_E, 4'd1);
        pushExp(c + 1, S_SRCA_E, 4'd1);

        // LUI, SRAI, ADDI with bit 30 set, SH
        step(); c = cyc;
        applyStimulus(OP_LUI, 3'b000, 1'b0);
        pushExp(c, S_IMM_D, 4'd3);
        pushExp(c + 1, S_ALU_E, 4'd10);
        pushExp(c + 1, S_SRCB_E, 4'd1);
        step(); c = cyc;
        applyStimulus(OP_IMM, 3'b101, 1'b1);
        pushExp(c, S_ILL_D, 4'd0);
        pushExp(c + 1, S_ALU_E, 4'd9);
        step(); c = cyc;
        applyStimulus(OP_IMM, 3'b000, 1'b1);
        pushExp(c, S_ILL_D, 4'd0);
        pushExp(c + 1, S_ALU_E, 4'd0);
        pushExp(c + 1, S_RW_E, 4'd1);
        step(); c = cyc;
        applyStimulus(OP_STORE, 3'b001, 1'b0);
        pushExp(c, S_IMM_D, 4'd1);
        pushExp(c + 2, S_MW_M, 4'd1);
        pushExp(c + 2, S_F3_M, 4'd1);
        pushExp(c + 2, S_RW_M, 4'd0);

        // LW then one stall cycle with a SUB waiting in D
        step(); c = cyc;
        applyStimulus(OP_LOAD, 3'b010, 1'b0);
        pushExp(c, S_IMM_D, 4'd0);
        step();
        stall_e = 1'b1;
        applyStimulus(OP_REG, 3'b000, 1'b1);
        pushExp(c + 1, S_ALU_E, 4'd0);
        pushExp(c + 1, S_RS_E, 4'd1);
        pushExp(c + 1, S_RW_E, 4'd1);
        step();
        stall_e = 1'b0;
        idle();
        pushExp(c + 2, S_ALU_E, 4'd0);
        pushExp(c + 2, S_RS_E, 4'd1);
        pushExp(c + 2, S_F3_M, 4'd2);
        pushExp(c + 2, S_RW_M, 4'd1);
        step();
        pushExp(c + 3, S_RW_E, 4'd0);
        pushExp(c + 3, S_F3_M, 4'd2);
        pushExp(c + 4, S_RS_W, 4'd1);

        // Stall and flush together behind a JAL
        step(); c = cyc;
        applyStimulus(OP_JAL, 3'b000, 1'b0);
        pushExp(c + 1, S_PCSRC_E, 4'd1);
        pushExp(c + 1, S_RW_E, 4'd1);
        step();
        stall_e = 1'b1;
        flush_e = 1'b1;
        applyStimulus(OP_REG, 3'b000, 1'b0);
        step();
        stall_e = 1'b0;
        flush_e = 1'b0;
        idle();
        pushExp(c + 2, S_RW_E, 4'd0);
        pushExp(c + 2, S_PCSRC_E, 4'd0);
        pushExp(c + 2, S_RS_E, 4'd0);

        // Flush alone discards a legal ADDI
        step(); c = cyc;
        flush_e = 1'b1;
        applyStimulus(OP_IMM, 3'b000, 1'b0);
        step();
        flush_e = 1'b0;
        idle();
        pushExp(c + 1, S_RW_E, 4'd0);

        // Illegal instructions
        step(); c = cyc;
        applyStimulus(7'b0000000, 3'b000, 1'b0);
        pushExp(c, S_ILL_D, 4'd1);
        pushExp(c + 1, S_RW_E, 4'd0);
        pushExp(c + 2, S_RW_M, 4'd0);
        pushExp(c + 3, S_RW_W, 4'd0);
        step(); c = cyc;
        applyStimulus(OP_STORE, 3'b100, 1'b0);
        pushExp(c, S_ILL_D, 4'd1);
        pushExp(c + 2, S_MW_M, 4'd0);
        step(); c = cyc;
        applyStimulus(OP_REG, 3'b111, 1'b1);
        pushExp(c, S_ILL_D, 4'd1);
        pushExp(c + 1, S_RW_E, 4'd0);
        step(); c = cyc;
        applyStimulus(OP_BRANCH, 3'b010, 1'b0);
        pushExp(c, S_ILL_D, 4'd1);
        step();
        setFlags(1'b1, 1'b1, 1'b1);
        idle();
        pushExp(c + 1, S_PCSRC_E, 4'd0);
        step();
        setFlags(1'b0, 1'b0, 1'b0);

        // Reset mid-stream with ADDIs filling E, M and W
        step(); c = cyc;
        applyStimulus(OP_IMM, 3'b000, 1'b0);
        step(); step(); step();
        pushExp(c + 3, S_RW_E, 4'd1);
        pushExp(c + 3, S_RW_M, 4'd1);
        pushExp(c + 3, S_RW_W, 4'd1);
        step();
        rst = 1'b1;
        applyStimulus(OP_JAL, 3'b000, 1'b0);
        pushExp(c + 4, S_RW_E, 4'd0);
        pushExp(c + 4, S_RW_M, 4'd0);
        pushExp(c + 4, S_RW_W, 4'd0);
        pushExp(c + 4, S_PCSRC_E, 4'd0);
        step();
        rst = 1'b0;
        applyStimulus(OP_REG, 3'b000, 1'b1);
        pushExp(c + 5, S_RW_E, 4'd0);
        pushExp(c + 6, S_ALU_E, 4'd1);
        pushExp(c + 6, S_RW_E, 4'd1);
        pushExp(c + 6, S_RW_M, 4'd0);
        step();
        idle();

        repeat (5) step();

        while (sb.size() > 0) begin
            checks++;
            $display("[TB] FAIL %s cycle %0d: never sampled, expected %0d",
                     sigName(sb[0].sig), sb[0].cyc, sb[0].val);
            void'(sb.pop_front());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
